// File: rtl/multdiv_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit.
// Holds FSM state encodings, iteration count and the INT_MIN constant.
// Also provides the multiply overflow test applied to the full product.
package multdiv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int         ITERATIONS = 32;
    localparam logic [5:0] LAST_ITER  = 6'(ITERATIONS - 1);

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // The product fits in 32 signed bits only when bits [63:31] are all equal.
    function automatic logic mul_overflow(input logic [63:0] prod);
        return !((&prod[63:31]) || !(|prod[63:31]));
    endfunction

endpackage

// File: rtl/multdiv_ctrl.sv
// Sequencer for multdiv_unit: state, 0..31 iteration counter, start arbitration.
// Latency: start at cycle 0, iterations in cycles 1-32, rdy_o in cycle 33.
// Backpressure: none; any start restarts the sequence, MULT wins over DIV.
module multdiv_ctrl
    import multdiv_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mult_i,
    input  logic       div_i,
    output logic [1:0] state_o,
    output logic       start_o,
    output logic       iter_o,
    output logic       last_o,
    output logic       rdy_o
);

    logic [1:0] state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    assign start_o = mult_i | div_i;
    assign iter_o  = (state_q == ST_MULT) || (state_q == ST_DIV);
    assign last_o  = iter_o && (cnt_q == LAST_ITER);
    assign rdy_o   = (state_q == ST_DONE);
    assign state_o = state_q;

    // Next state: iterate to the last count, then one DONE cycle; a start overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_MULT, ST_DIV: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = state_q;
        endcase
        if (mult_i) begin
            state_d = ST_MULT;
            cnt_d   = '0;
        end else if (div_i) begin
            state_d = ST_DIV;
            cnt_d   = '0;
        end
    end

    // State and counter registers; reset masks a coincident start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/thirty_two_bit_adder.sv
// 32-bit carry-lookahead adder/subtractor (sub_i=1 computes a_i - b_i).
// Latency: purely combinational, zero cycles.
// Backpressure: none; result follows the inputs every cycle.
module thirty_two_bit_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [31:0] b_eff;
    logic [31:0] gen;
    logic [31:0] prop;
    logic [32:0] carry;

    // Carries resolved by 4-bit lookahead groups chained on group carry-in.
    function automatic logic [32:0] cla_carries(input logic [31:0] g,
                                                input logic [31:0] p,
                                                input logic        cin);
        logic [32:0] c;
        logic [3:0]  gg;
        logic [3:0]  pp;
        logic        c0;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            gg = g[4*k +: 4];
            pp = p[4*k +: 4];
            c0 = c[4*k];
            c[4*k+1] = gg[0] | (pp[0] & c0);
            c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
            c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | ((&pp[2:0]) & c0);
            c[4*k+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                     | ((&pp[3:1]) & gg[0]) | ((&pp) & c0);
        end
        return c;
    endfunction

    // Subtraction is a + ~b + 1.
    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        gen   = a_i & b_eff;
        prop  = a_i ^ b_eff;
        carry = cla_carries(gen, prop, sub_i);
    end

    assign sum_o  = prop ^ carry[31:0];
    assign cout_o = carry[32];

endmodule

// File: rtl/multdiv_unit.sv
// Signed 32-bit multiplier (radix-2 Booth) and divider (restoring on magnitudes).
// Latency: 33 cycles from start pulse to the one-cycle data_resultRDY pulse.
// Backpressure: none; the pipeline stalls externally, a new start aborts silently.
module multdiv_unit
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    logic [1:0]  state;
    logic        start, iter, last;

    // a_q: multiplicand (MULT) / raw dividend for its sign (DIV); b_q: raw divisor.
    logic [31:0] a_q, b_q;
    // hi_q/lo_q: {upper, lower} for MULT, {rem, quo} for DIV.
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        qm1_q, qm1_d;
    logic        dz_q, ovf_q;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;

    logic [31:0] step_a, step_b, step_sum;
    logic        step_sub, step_cout;
    logic [32:0] upper33;
    logic [31:0] neg_b, neg_sum, abs_a;
    logic        unused_neg_cout;

    multdiv_ctrl u_ctrl (
        .clk_i   (clock),
        .rst_i   (reset),
        .mult_i  (ctrl_MULT),
        .div_i   (ctrl_DIV),
        .state_o (state),
        .start_o (start),
        .iter_o  (iter),
        .last_o  (last),
        .rdy_o   (data_resultRDY)
    );

    // Step adder operand select. The divider never forms |B|: adding a negative B
    // or subtracting a positive B both yield rem - |B|, and carry-out means no borrow.
    always_comb begin
        if (state == ST_DIV) begin
            step_a   = {hi_q[30:0], lo_q[31]};
            step_b   = b_q;
            step_sub = ~b_q[31];
        end else begin
            step_a   = hi_q;
            step_b   = a_q;
            step_sub = lo_q[0] & ~qm1_q;
        end
    end

    thirty_two_bit_adder u_step (
        .a_i    (step_a),
        .b_i    (step_b),
        .sub_i  (step_sub),
        .sum_o  (step_sum),
        .cout_o (step_cout)
    );

    // One iteration. Booth keeps a 33rd upper bit recovered from the carry so that
    // A = INT_MIN cannot overflow before the arithmetic shift.
    always_comb begin
        upper33 = {hi_q[31], hi_q};
        if (lo_q[0] ^ qm1_q) begin
            upper33 = {hi_q[31] ^ (step_sub ? ~a_q[31] : a_q[31]) ^ step_cout, step_sum};
        end
        if (state == ST_DIV) begin
            hi_d  = step_cout ? step_sum : step_a;
            lo_d  = {lo_q[30:0], step_cout};
            qm1_d = qm1_q;
        end else begin
            hi_d  = upper33[32:1];
            lo_d  = {upper33[0], lo_q[31:1]};
            qm1_d = lo_q[0];
        end
    end

    // Negator: |A| on a start cycle, otherwise the sign fix of the final quotient.
    assign neg_b = start ? data_operandA : lo_d;

    thirty_two_bit_adder u_neg (
        .a_i    (32'h0000_0000),
        .b_i    (neg_b),
        .sub_i  (1'b1),
        .sum_o  (neg_sum),
        .cout_o (unused_neg_cout)
    );

    assign abs_a = data_operandA[31] ? neg_sum : data_operandA;

    // Result and exception as seen at the end of the last iteration.
    always_comb begin
        if (state == ST_DIV) begin
            if (dz_q) begin
                res_d = 32'h0000_0000;
                exc_d = 1'b1;
            end else if (ovf_q) begin
                res_d = INT_MIN;
                exc_d = 1'b1;
            end else begin
                res_d = (a_q[31] ^ b_q[31]) ? neg_sum : lo_d;
                exc_d = 1'b0;
            end
        end else begin
            res_d = lo_d;
            exc_d = mul_overflow({hi_d, lo_d});
        end
    end

    // Datapath registers: load on start, step while iterating, capture result on the last step.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            qm1_q <= 1'b0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
            res_q <= '0;
            exc_q <= 1'b0;
        end else if (start) begin
            a_q   <= data_operandA;
            b_q   <= data_operandB;
            hi_q  <= '0;
            lo_q  <= ctrl_MULT ? data_operandB : abs_a;
            qm1_q <= 1'b0;
            dz_q  <= (data_operandB == 32'h0000_0000);
            ovf_q <= (data_operandA == INT_MIN) && (data_operandB == 32'hFFFF_FFFF);
        end else if (iter) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            qm1_q <= qm1_d;
            if (last) begin
                res_q <= res_d;
                exc_q <= exc_d;
            end
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit with hand-computed expected values.
// Cycle k is the interval after the k-th rising edge following the start cycle.
// Outputs are sampled 1ns after each rising edge.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start, leaving the bench in cycle 1 with scrambled operands.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        tick();
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // From cycle 1 of an operation: RDY must stay low for 32 cycles, then pulse.
    task automatic run_to_done(input string tag);
        int early;
        early = 0;
        repeat (32) begin
            if (data_resultRDY) early++;
            tick();
        end
        check({tag, "_early_rdy"}, early, 0);
        check({tag, "_rdy"}, {31'd0, data_resultRDY}, 1);
    endtask

    task automatic do_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc);
        start_op(m, d, a, b);
        run_to_done(tag);
        check({tag, "_res"}, data_result, exp_res);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
    endtask

    initial begin
        int late;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) tick();
        check("reset_res", data_result, 32'h0);
        check("reset_exc", {31'd0, data_exception}, 0);
        check("reset_rdy", {31'd0, data_resultRDY}, 0);
        reset = 1'b0;
        tick();

        // 7 * -3 = -21
        do_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        tick();
        check("mul_7_m3_rdy_c34", {31'd0, data_resultRDY}, 0);
        repeat (3) tick();
        check("mul_hold_res", data_result, 32'hFFFF_FFEB);

        do_op("mul_2p32", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
        tick();
        do_op("mul_max_1", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h7FFF_FFFF, 1'b0);
        tick();
        // INT_MIN * -1 = +2^31: low word 0x80000000, does not fit in 32 signed bits
        do_op("mul_min_m1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        tick();
        // INT_MIN * INT_MIN = 2^62
        do_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1);
        tick();
        // -5 * -6 = 30
        do_op("mul_m5_m6", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30, 1'b0);
        tick();

        do_op("div_m100_7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
        tick();
        do_op("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
        tick();
        do_op("div_m100_m7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);
        tick();
        do_op("div_5_0", 1'b0, 1'b1, 32'd5, 32'h0, 32'h0, 1'b1);
        tick();
        do_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        tick();
        // INT_MIN / 2 = -2^30
        do_op("div_min_2", 1'b0, 1'b1, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0);
        tick();
        do_op("div_3_7", 1'b0, 1'b1, 32'd3, 32'd7, 32'h0, 1'b0);
        tick();

        // Abort: MULT 3*4 at cycle 0, DIV 100/10 at cycle 10 -> single RDY at cycle 43.
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) tick();
        start_op(1'b0, 1'b1, 32'd100, 32'd10);
        run_to_done("abort");
        check("abort_res", data_result, 32'd10);
        check("abort_exc", {31'd0, data_exception}, 0);
        tick();

        // Both starts high: MULT wins.
        do_op("both_6_3", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);
        tick();

        // Start coincident with RDY: 5*6 completes, 7/2 starts in that same cycle.
        do_op("b2b_mul", 1'b1, 1'b0, 32'd5, 32'd6, 32'd30, 1'b0);
        do_op("b2b_div", 1'b0, 1'b1, 32'd7, 32'd2, 32'd3, 1'b0);
        tick();

        // Reset at cycle 15 of a DIV, with a start pulse that must be ignored.
        start_op(1'b0, 1'b1, 32'd1000, 32'd10);
        repeat (14) tick();
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        tick();
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        check("rst_mid_res", data_result, 32'h0);
        check("rst_mid_exc", {31'd0, data_exception}, 0);
        check("rst_mid_rdy", {31'd0, data_resultRDY}, 0);
        late = 0;
        repeat (44) begin
            tick();
            if (data_resultRDY) late++;
        end
        check("rst_no_rdy", late, 0);
        check("rst_hold_res", data_result, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
